// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Imported by the storage array and the responder top.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_BASE     = 32'h8000_0000;
  localparam logic [31:0] IMEM_ERR_DATA = 32'h0000_0000;
  localparam int          IMEM_CNT_W    = 4;

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous write port, one synchronous read port.
// A same-edge read and write to one word returns the old contents.
module imem_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_idx,
  input  logic [31:0]   i_ld_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_idx,
  output logic [31:0]   o_rd_data
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd;

  always_ff @(posedge clk) begin
    if (i_ld_en) r_mem[i_ld_idx] <= i_ld_data;
    if (i_rd_en) r_rd <= r_mem[i_rd_idx];
  end

  assign o_rd_data = r_rd;

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts one word address, answers after LATENCY
// cycles over valid/ready; flush cancels the outstanding fetch.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = IMEM_BASE,
  parameter int          LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  state_t                r_state;
  state_t                w_next;
  logic [IMEM_CNT_W-1:0] r_cnt;
  logic                  r_err;
  logic                  r_hit;
  logic [31:0]           w_off;
  logic [31:0]           w_rd;
  logic [AW-1:0]         w_idx;
  logic                  w_err;
  logic                  w_accept;

  assign w_off = req_addr - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];
  assign w_err = (req_addr[1:0] != 2'b00)
              || (req_addr < BASE_ADDR)
              || (w_off >= SPAN);

  // flush outranks a coincident request in IDLE
  assign w_accept = (r_state == IDLE) && req_valid && !flush;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .i_ld_en   (ld_en),
    .i_ld_idx  (ld_idx),
    .i_ld_data (ld_data),
    .i_rd_en   (w_accept && !w_err),
    .i_rd_idx  (w_idx),
    .o_rd_data (w_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept)
              w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (flush)
              w_next = IDLE;
            else if (r_cnt == IMEM_CNT_W'(1))
              w_next = RESP;
      RESP: if (flush || rsp_ready)
              w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
      r_hit <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= IMEM_CNT_W'(LATENCY - 1);
        r_err <= w_err;
        r_hit <= !w_err;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - IMEM_CNT_W'(1);
      end
    end
  end

  // array output only updates on accept, so it holds through RESP
  assign rsp_data = r_hit ? w_rd : IMEM_ERR_DATA;
  assign rsp_err  = r_err;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the core's fetch requests.
- Accepts one word-aligned fetch address per request and returns the 32-bit instruction after a fixed, parameterised latency over a valid/ready handshake.
- Sits between the core's PC/fetch logic and word storage; storage is preloaded through a side write port.
- One request outstanding at a time; flush cancels it on branch redirect.

Parameters:
- DEPTH, 4096, number of 32-bit words of storage (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from the accepting edge to rsp_valid high (legal 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address of the instruction.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_data  output  32  instruction word.
- rsp_err  output  1  address misaligned or out of range.
- flush  input  1  cancel the outstanding request.
- ld_en  input  1  preload write enable.
- ld_idx  input  $clog2(DEPTH)  preload word index.
- ld_data  input  32  preload word.

Behaviour:
- Reset (rst low, async): state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0. Storage contents are not cleared.
- Reset mid-operation drops any pending request; no response is issued after release.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting.
  - RESP: rsp_valid=1.
- IDLE -> WAIT on req_valid at a rising edge. At that edge:
  - word index = (req_addr-BASE_ADDR)>>2 is read and registered.
  - err is computed and registered.
  - counter loads LATENCY-1.
  - If LATENCY==1, go directly to RESP.
- WAIT: counter decrements each cycle; at counter==1 go to RESP on the next edge. rsp_valid therefore rises exactly LATENCY cycles after the accepting edge.
- RESP: rsp_data and rsp_err are held stable while rsp_ready=0. On rsp_ready=1, go to IDLE at that edge. req_ready is high the following cycle.
- No back-to-back acceptance. Maximum throughput is one fetch per LATENCY+1 cycles.
- Error conditions:
  - req_addr[1:0]!=0, or req_addr<BASE_ADDR, or req_addr>=BASE_ADDR+4*DEPTH, sets rsp_err=1 and rsp_data=32'h0000_0000.
  - No storage read occurs.
  - Error responses use the same latency and handshake as normal responses.
- flush:
  - In WAIT or RESP: go to IDLE at the next edge, rsp_valid low from then, response discarded.
  - In IDLE: ignored; a coincident req_valid is NOT accepted (flush has priority).
  - Coincident with rsp_valid&&rsp_ready: the handshake counts as completed; go to IDLE.
- Preload:
  - ld_en writes ld_data to ld_idx at the rising edge, in any state.
  - Read data is captured at the accept edge. A same-edge write to the same word returns the OLD value (read-before-write).
  - Writes after acceptance do not alter the pending response.
- req_addr is sampled only at the accept edge; it may change afterwards.
- Address arithmetic is 32-bit unsigned, with no wrap of BASE_ADDR+4*DEPTH past 2^32 (guaranteed by the parameter choice).

Decomposition:
- Shared package imem_pkg:
  - state enum (IDLE, WAIT, RESP).
  - IMEM_BASE default 32'h8000_0000.
  - IMEM_ERR_DATA 32'h0.
  - width localparam for the latency counter (4 bits).
- One sub-module, imem_array: DEPTH x 32 storage with one synchronous write port (ld_*) and one synchronous read port (index, read enable). Read-before-write on collision; no reset.
- FSM, counter, range check and output registers live in imem_responder.

Test Plan:
1. Preload idx0=32'h0000_0513, idx1=32'h0010_0073. Request 0x8000_0000 with LATENCY=2, rsp_ready=1 -> rsp_valid high 2 cycles after accept, rsp_data=32'h0000_0513, rsp_err=0, req_ready high the cycle after handshake.
2. Request 0x8000_0004 with rsp_ready held low 5 cycles -> rsp_valid stays high, rsp_data=32'h0010_0073 stable for all 5 cycles, completes on the cycle rsp_ready=1.
3. Requests 0x8000_0002 and 0x7FFF_FFFC -> each gives rsp_err=1, rsp_data=0 at the normal latency. Request 0x8000_0000+4*DEPTH -> rsp_err=1.
4. Accept 0x8000_0000, assert flush one cycle later in WAIT -> rsp_valid never rises, req_ready=1 next cycle. A new request to 0x8000_0004 returns 32'h0010_0073.
5. Same edge: accept 0x8000_0000 and ld_en to idx0 with 32'hDEAD_BEEF -> response is 32'h0000_0513. A following request returns 32'hDEAD_BEEF.
6. Drive rst low asynchronously mid-WAIT -> rsp_valid=0, req_ready=1 immediately. After release there is no stale response, and preloaded data is intact.
